// File: rtl/microc_stk_if.sv
// Bus between the microc_stk datapath and its control unit / program memory.
// The slave side is the datapath. The master side is the control unit, which
// supplies instructions and selects and observes pc, flags and the stack state.
interface microc_stk_if #(
    parameter int PCW   = 10,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [15:0]     instr;
    logic [PCW-1:0]  pc;
    logic [5:0]      Opcode;
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [2:0]      Op;
    logic            push;
    logic            pop;
    logic            z;
    logic            c;
    logic [SPW-1:0]  sp;
    logic [1:0]      stk_err;

    modport master (
        output instr, s_inc, s_inm, we3, wez, Op, push, pop,
        input  pc, Opcode, z, c, sp, stk_err
    );

    modport slave (
        input  instr, s_inc, s_inm, we3, wez, Op, push, pop,
        output pc, Opcode, z, c, sp, stk_err
    );
endinterface

// File: rtl/microc_stk.sv
// microc_stk: single-cycle microcontroller datapath. It has a 16-entry
// register file, an ALU with zero and carry flags, and a return-address
// stack for call, return and swap.
// Optional build macro MICROC_STK_TRAP_EN: when it is defined, a stack
// overflow or underflow sends pc to TRAP_VEC instead of pc+1.
module microc_stk #(
    parameter int             DW       = 8,
    parameter int             PCW      = 10,
    parameter int             DEPTH    = 4,
    parameter logic [PCW-1:0] TRAP_VEC = '0
) (
    input  logic         clk,
    input  logic         reset,
    microc_stk_if.slave  bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

`ifdef MICROC_STK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [DW-1:0]  r_rf  [16];
    logic [PCW-1:0] r_stk [DEPTH];
    logic [PCW-1:0] r_pc;
    logic           r_z;
    logic           r_c;
    logic [SPW-1:0] r_sp;
    logic [1:0]     r_err;

    logic [3:0]     w_ra1, w_ra2, w_wa3;
    logic [DW-1:0]  w_rd1, w_rd2, w_imm, w_a, w_b, w_res;
    logic [DW:0]    w_sum;
    logic           w_zr, w_cr;
    logic [PCW-1:0] w_pc_inc, w_tgt, w_tos, w_pc_nxt, w_stk_wd;
    logic [SPW-1:0] w_sp_nxt;
    logic [IW-1:0]  w_tos_idx, w_stk_idx;
    logic           w_sp_nz, w_sp_full, w_of, w_uf, w_stk_we;

    // Register-file addressing. In immediate mode the second read port takes
    // its address from the low nibble, so the ALU B input is the
    // destination register.
    assign w_ra1 = bus.instr[11:8];
    assign w_ra2 = bus.s_inm ? bus.instr[3:0] : bus.instr[7:4];
    assign w_wa3 = bus.instr[3:0];
    assign w_rd1 = (w_ra1 == 4'd0) ? '0 : r_rf[w_ra1];
    assign w_rd2 = (w_ra2 == 4'd0) ? '0 : r_rf[w_ra2];
    assign w_imm = DW'(bus.instr[11:4]);
    assign w_a   = bus.s_inm ? w_imm : w_rd1;
    assign w_b   = w_rd2;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    // ALU: result plus carry (add) or borrow (sub). Other ops clear the carry.
    always_comb begin
        w_res = w_a;
        w_cr  = 1'b0;
        case (bus.Op)
            3'b000: w_res = w_a;
            3'b001: w_res = ~w_a;
            3'b010: begin w_res = w_sum[DW-1:0]; w_cr = w_sum[DW]; end
            3'b011: begin w_res = w_a - w_b;     w_cr = (w_a < w_b); end
            3'b100: w_res = w_a & w_b;
            3'b101: w_res = w_a | w_b;
            3'b110: w_res = -w_a;
            3'b111: w_res = -w_b;
            default: w_res = w_a;
        endcase
    end
    assign w_zr = (w_res == '0);

    // The pc and sp arithmetic wraps naturally at its register width.
    assign w_pc_inc  = r_pc + PCW'(1);
    assign w_tgt     = bus.instr[PCW-1:0];
    assign w_sp_nz   = (r_sp != '0);
    assign w_sp_full = (r_sp == SPW'(DEPTH));
    assign w_tos_idx = IW'(r_sp - SPW'(1));
    assign w_tos     = r_stk[w_tos_idx];

    // Next pc, sp and stack write, in priority order: swap, return, call,
    // then sequential or jump. An illegal stack op leaves the stack alone.
    always_comb begin
        w_pc_nxt  = bus.s_inc ? w_pc_inc : w_tgt;
        w_sp_nxt  = r_sp;
        w_stk_we  = 1'b0;
        w_stk_idx = r_sp[IW-1:0];
        w_stk_wd  = w_pc_inc;
        w_of      = 1'b0;
        w_uf      = 1'b0;
        if (bus.push && bus.pop) begin
            if (w_sp_nz) begin
                w_pc_nxt  = w_tos;
                w_stk_we  = 1'b1;
                w_stk_idx = w_tos_idx;
            end else begin
                w_uf = 1'b1;
            end
        end else if (bus.pop) begin
            if (w_sp_nz) begin
                w_pc_nxt = w_tos;
                w_sp_nxt = r_sp - SPW'(1);
            end else begin
                w_uf = 1'b1;
            end
        end else if (bus.push) begin
            if (!w_sp_full) begin
                w_pc_nxt = w_tgt;
                w_sp_nxt = r_sp + SPW'(1);
                w_stk_we = 1'b1;
            end else begin
                w_of = 1'b1;
            end
        end
        if (w_of || w_uf)
            w_pc_nxt = TRAP_EN ? TRAP_VEC : w_pc_inc;
    end

    // Control state: pc, flags, stack pointer and the sticky error bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_sp  <= '0;
            r_err <= 2'b00;
        end else begin
            r_pc  <= w_pc_nxt;
            r_sp  <= w_sp_nxt;
            r_err <= r_err | {w_of, w_uf};
            if (bus.wez) begin
                r_z <= w_zr;
                r_c <= w_cr;
            end
        end
    end

    // Register file. r0 is never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else if (bus.we3 && (w_wa3 != 4'd0)) begin
            r_rf[w_wa3] <= w_res;
        end
    end

    // Return-address storage. It is not reset, because sp gates every read.
    always_ff @(posedge clk) begin
        if (!reset && w_stk_we)
            r_stk[w_stk_idx] <= w_stk_wd;
    end

    assign bus.pc      = r_pc;
    assign bus.Opcode  = bus.instr[15:10];
    assign bus.z       = r_z;
    assign bus.c       = r_c;
    assign bus.sp      = r_sp;
    assign bus.stk_err = r_err;
endmodule

// File: tb/tb_microc_stk.sv
// Directed bench for microc_stk (DW=8, PCW=10, DEPTH=4).
module tb_microc_stk;
    localparam logic [9:0] TV = 10'h3A0;
`ifdef MICROC_STK_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    microc_stk_if #(.PCW(10), .DEPTH(4)) bus_if ();

    microc_stk #(.DW(8), .PCW(10), .DEPTH(4), .TRAP_VEC(TV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction's worth of control inputs, then clock it in.
    task automatic cyc(input logic [15:0] ins, input logic inc, input logic inm,
                       input logic we, input logic wz, input logic [2:0] op,
                       input logic ps, input logic pp);
        bus_if.instr = ins;  bus_if.s_inc = inc; bus_if.s_inm = inm;
        bus_if.we3   = we;   bus_if.wez   = wz;  bus_if.Op    = op;
        bus_if.push  = ps;   bus_if.pop   = pp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 0);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 0);
        reset = 1'b0;
        chk("rst_pc", bus_if.pc, 0);
        chk("rst_z", bus_if.z, 0);
        chk("rst_c", bus_if.c, 0);
        chk("rst_sp", bus_if.sp, 0);
        chk("rst_err", bus_if.stk_err, 0);

        bus_if.instr = 16'h1232;
        #1 chk("opcode", bus_if.Opcode, 6'h04);
        cyc(16'h1232, 1, 1, 1, 0, 3'b000, 0, 0);
        chk("imm_r2", dut.r_rf[2], 8'h23);
        chk("pc_inc", bus_if.pc, 1);

        // Try to write r0, then read it back through the ALU into z.
        cyc(16'h1FF0, 1, 1, 1, 0, 3'b000, 0, 0);
        cyc(16'h0000, 1, 0, 0, 1, 3'b000, 0, 0);
        chk("r0_zero", bus_if.z, 1);

        cyc(16'h0FF1, 1, 1, 1, 0, 3'b000, 0, 0);   // r1 = FF
        cyc(16'h0012, 1, 1, 1, 0, 3'b000, 0, 0);   // r2 = 01
        cyc(16'h0123, 1, 0, 1, 1, 3'b010, 0, 0);   // r3 = r1 + r2
        chk("add_res", dut.r_rf[3], 8'h00);
        chk("add_z", bus_if.z, 1);
        chk("add_c", bus_if.c, 1);

        cyc(16'h0011, 1, 1, 1, 0, 3'b000, 0, 0);   // r1 = 01
        cyc(16'h0022, 1, 1, 1, 0, 3'b000, 0, 0);   // r2 = 02
        cyc(16'h0123, 1, 0, 1, 1, 3'b011, 0, 0);   // r3 = r1 - r2
        chk("sub_res", dut.r_rf[3], 8'hFF);
        chk("sub_z", bus_if.z, 0);
        chk("sub_c", bus_if.c, 1);

        cyc(16'h0124, 1, 0, 1, 1, 3'b100, 0, 0);   // and
        chk("and_res", dut.r_rf[4], 8'h00);
        chk("and_z", bus_if.z, 1);
        chk("and_c", bus_if.c, 0);
        cyc(16'h0124, 1, 0, 1, 0, 3'b101, 0, 0);   // or, flags held
        chk("or_res", dut.r_rf[4], 8'h03);
        chk("hold_z", bus_if.z, 1);
        cyc(16'h0124, 1, 0, 1, 1, 3'b110, 0, 0);   // -A
        chk("nega_res", dut.r_rf[4], 8'hFF);
        chk("nega_z", bus_if.z, 0);
        cyc(16'h0124, 1, 0, 1, 1, 3'b111, 0, 0);   // -B
        chk("negb_res", dut.r_rf[4], 8'hFE);
        cyc(16'h0F04, 1, 1, 1, 0, 3'b001, 0, 0);   // ~imm(F0)
        chk("not_res", dut.r_rf[4], 8'h0F);
        chk("pc_seq", bus_if.pc, 14);

        // Call and return.
        cyc(16'h0005, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("jump", bus_if.pc, 5);
        cyc(16'h0040, 1, 0, 0, 0, 3'b000, 1, 0);
        chk("call_pc", bus_if.pc, 10'h040);
        chk("call_sp", bus_if.sp, 1);
        chk("call_tos", dut.r_stk[0], 6);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        chk("ret_pc", bus_if.pc, 6);
        chk("ret_sp", bus_if.sp, 0);

        // Fill the stack, then overflow while also writing a register.
        cyc(16'h0100, 1, 0, 0, 0, 3'b000, 1, 0);
        cyc(16'h0110, 1, 0, 0, 0, 3'b000, 1, 0);
        cyc(16'h0120, 1, 0, 0, 0, 3'b000, 1, 0);
        cyc(16'h0130, 1, 0, 0, 0, 3'b000, 1, 0);
        chk("full_sp", bus_if.sp, 4);
        chk("full_pc", bus_if.pc, 10'h130);
        cyc(16'h0145, 1, 1, 1, 0, 3'b000, 1, 0);
        chk("ovf_pc", bus_if.pc, TRAP ? TV : 10'h131);
        chk("ovf_sp", bus_if.sp, 4);
        chk("ovf_err", bus_if.stk_err, 2'b10);
        chk("ovf_wr", dut.r_rf[5], 8'h14);
        chk("ovf_stk", dut.r_stk[3], 10'h121);

        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        chk("pop3_pc", bus_if.pc, 10'h121);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        chk("pop2_pc", bus_if.pc, 10'h111);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        chk("pop1_pc", bus_if.pc, 10'h101);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        chk("pop0_pc", bus_if.pc, 7);
        chk("pop0_sp", bus_if.sp, 0);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        chk("udf_pc", bus_if.pc, TRAP ? TV : 10'h008);
        chk("udf_sp", bus_if.sp, 0);
        chk("udf_err", bus_if.stk_err, 2'b11);

        // Swap at sp=1.
        cyc(16'h000F, 0, 0, 0, 0, 3'b000, 0, 0);
        cyc(16'h0020, 1, 0, 0, 0, 3'b000, 1, 0);
        chk("swp0_tos", dut.r_stk[0], 10'h010);
        chk("swp0_pc", bus_if.pc, 10'h020);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 1, 1);
        chk("swap_pc", bus_if.pc, 10'h010);
        chk("swap_tos", dut.r_stk[0], 10'h021);
        chk("swap_sp", bus_if.sp, 1);

        // pc wrap.
        cyc(16'h03FF, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("pc_max", bus_if.pc, 10'h3FF);
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 0, 0);
        chk("pc_wrap", bus_if.pc, 0);

        // Reset wins over a push.
        reset = 1'b1;
        cyc(16'h0200, 1, 0, 0, 0, 3'b000, 1, 0);
        reset = 1'b0;
        chk("rp_pc", bus_if.pc, 0);
        chk("rp_sp", bus_if.sp, 0);
        chk("rp_err", bus_if.stk_err, 0);
        chk("rp_r2", dut.r_rf[2], 0);

        // Swap with an empty stack is an underflow.
        cyc(16'h0000, 1, 0, 0, 0, 3'b000, 1, 1);
        chk("swu_err", bus_if.stk_err, 2'b01);
        chk("swu_sp", bus_if.sp, 0);
        chk("swu_pc", bus_if.pc, TRAP ? TV : 10'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/microc_stk.md
Name: microc_stk

Overview:
- Parametrised single-cycle microcontroller datapath; successor to the 8-bit/10-bit-PC core.
- Adds configurable data and PC width, a carry flag and a hardware return-address stack (call/return/swap) with overflow/underflow detection.
- Program memory is external (asynchronous read of `pc`). The control unit drives all select/enable inputs from `Opcode`, `z` and `c`.

Parameters:
- DW, 8, data/register width; legal 8..32. Immediate instr[11:4] is zero-extended to DW.
- PCW, 10, program counter width; legal 4..10. Jump target is instr[PCW-1:0].
- DEPTH, 4, return-stack entries; legal 2..16.
- TRAP_VEC, 0, PCW-bit trap address; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr  in  16  instruction at address `pc`, valid in the same cycle
- pc  out  PCW  current program counter
- Opcode  out  6  instr[15:10]
- s_inc  in  1  1: next pc = pc+1; 0: next pc = jump target
- s_inm  in  1  1: ALU A = immediate, RA2 = instr[3:0]; 0: ALU A = rd1, RA2 = instr[7:4]
- we3  in  1  register-file write enable
- wez  in  1  flag update enable (z and c together)
- Op  in  3  ALU operation
- push  in  1  call: push pc+1, jump to target
- pop  in  1  return: pc <= top of stack
- z  out  1  registered zero flag
- c  out  1  registered carry/borrow flag
- sp  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH
- stk_err  out  2  sticky {overflow, underflow}

Behaviour:
- Reset, sync at posedge, overrides all inputs: pc=0, z=0, c=0, sp=0, stk_err=0, all 16 registers cleared to 0. Stack contents are don't-care.
- Register file, 16xDW:
  - RA1=instr[11:8]; RA2 per s_inm; WA3=instr[3:0]; reads combinational.
  - r0 always reads 0; writes to r0 are ignored.
  - Write when we3=1: wd3 = ALU result, at posedge.
- ALU, combinational, DW bits:
  - Op 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 -A; 111 -B.
  - zr = (result==0).
  - cr = carry-out for 010; borrow (A<B unsigned) for 011; 0 otherwise.
  - wez=1: z<=zr, c<=cr. Otherwise z and c hold.
- Next-pc priority, evaluated each non-reset edge; all pc arithmetic wraps mod 2^PCW (pc+1 at all-ones gives 0):
  1. push&pop, sp>0 (swap): pc<=TOS, TOS<=pc+1, sp unchanged.
  2. push&pop, sp==0: underflow; sp unchanged.
  3. pop only, sp>0: pc<=TOS, sp<=sp-1.
  4. pop only, sp==0: underflow.
  5. push only, sp<DEPTH: stack[sp]<=pc+1, sp<=sp+1, pc<=instr[PCW-1:0].
  6. push only, sp==DEPTH: overflow; push discarded.
  7. Neither: pc <= s_inc ? pc+1 : instr[PCW-1:0].
- On overflow/underflow:
  - Set the corresponding stk_err bit (sticky until reset).
  - pc <= pc+1 (see Optional Feature).
  - Register and flag writes in that cycle still occur.
- Latency: all state updates take effect at the next posedge; single cycle per instruction; no stalls.
- sp never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: MICROC_STK_TRAP_EN.
- Defined: on overflow or underflow, pc <= TRAP_VEC instead of pc+1, and the stack is left unchanged.
- Undefined: pc <= pc+1; TRAP_VEC is unused.
- stk_err behaviour is identical in both builds.

Test Plan:
- Reset, then s_inm=1, instr=0x1232 (imm 0x23, WA3=2), Op=000, we3=1 -> r2=0x23, pc=1; next cycle with instr[3:0]=0 and we3=1 -> r0 still reads 0.
- r1=0xFF, r2=0x01, DW=8, s_inm=0, Op=010, wez=1 (result written to r3, instr=0x0123) -> r3=0x00, z=1, c=1; then Op=011 with r1=0x01, r2=0x02 -> result 0xFF, z=0, c=1.
- At pc=5, push with target 0x040 -> pc=0x040, sp=1, TOS=6; pop -> pc=6, sp=0.
- DEPTH=4: five nested pushes -> sp=4, stk_err=2'b10, pc = caller pc+1 (or TRAP_VEC with MICROC_STK_TRAP_EN); pop at sp=0 -> stk_err[0]=1.
- sp=1, TOS=0x010, pc=0x020, push&pop -> pc=0x010, TOS=0x021, sp=1.
- PCW=4, pc=0xF, s_inc=1 -> pc=0x0; reset asserted during a push -> pc=0, sp=0, stk_err=0 next cycle.
